// File: rtl/elelock_seq_if.sv
// Keypad-side and actuator-side signals of the multi-digit lock.
// The testbench drives through the master modport; the lock core uses the slave modport.
interface elelock_seq_if;
   logic [9:0] tenkey;
   logic       close;
   logic       lock;
   logic       alarm;
   logic [3:0] digit_cnt;
   logic [3:0] fail_cnt;

   modport master (output tenkey, output close,
                   input  lock, input alarm, input digit_cnt, input fail_cnt);
   modport slave  (input  tenkey, input close,
                   output lock, output alarm, output digit_cnt, output fail_cnt);
endinterface

// File: rtl/elelock_seq.sv
// Multi-digit keypad lock: collects a DIGITS-long BCD code, checks it against SECRET,
// and after MAX_FAIL consecutive misses holds a timed alarm lockout.
module elelock_seq #(
   parameter int                  DIGITS         = 4,
   parameter logic [4*DIGITS-1:0] SECRET         = 16'h7777,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   elelock_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_ENTRY   = 2'd0,
      S_CHECK   = 2'd1,
      S_OPEN    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   localparam logic [15:0] TIMER_LOAD = 16'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]  DIGITS_W   = 4'(DIGITS);
   localparam logic [4:0]  MAX_FAIL_W = 5'(MAX_FAIL);

   state_t                state_reg,     state_next;
   logic [4*DIGITS-1:0]   buffer_reg,    buffer_next;
   logic [3:0]            digit_cnt_reg, digit_cnt_next;
   logic [3:0]            fail_cnt_reg,  fail_cnt_next;
   logic [15:0]           timer_reg,     timer_next;
   logic [9:0]            prev_key_reg;

   logic                  key_onehot;
   logic                  key_accept;
   logic [3:0]            key_digit;
   logic [4*DIGITS-1:0]   buffer_shift;
   logic [4:0]            fail_inc;

   // Only a clean one-hot press that follows an all-zero cycle counts as a keystroke.
   assign key_onehot = (bus.tenkey != 10'd0) && ((bus.tenkey & (bus.tenkey - 10'd1)) == 10'd0);
   assign key_accept = key_onehot && (prev_key_reg == 10'd0);
   assign fail_inc   = {1'b0, fail_cnt_reg} + 5'd1;

   always_comb begin
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (bus.tenkey[i]) key_digit = 4'(i);
      end
   end

   generate
      if (DIGITS == 1) begin : g_shift_single
         assign buffer_shift = key_digit;
      end else begin : g_shift_multi
         assign buffer_shift = {buffer_reg[4*DIGITS-5:0], key_digit};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_ENTRY;
         buffer_reg    <= '0;
         digit_cnt_reg <= 4'd0;
         fail_cnt_reg  <= 4'd0;
         timer_reg     <= 16'd0;
         prev_key_reg  <= 10'd0;
      end else begin
         state_reg     <= state_next;
         buffer_reg    <= buffer_next;
         digit_cnt_reg <= digit_cnt_next;
         fail_cnt_reg  <= fail_cnt_next;
         timer_reg     <= timer_next;
         prev_key_reg  <= bus.tenkey;
      end
   end

   always_comb begin
      state_next     = state_reg;
      buffer_next    = buffer_reg;
      digit_cnt_next = digit_cnt_reg;
      fail_cnt_next  = fail_cnt_reg;
      timer_next     = timer_reg;
      case (state_reg)
         S_ENTRY: begin
            // close wins over a simultaneous key, which is dropped
            if (bus.close) begin
               buffer_next    = '0;
               digit_cnt_next = 4'd0;
            end else if (key_accept) begin
               buffer_next    = buffer_shift;
               digit_cnt_next = digit_cnt_reg + 4'd1;
               if (digit_cnt_reg + 4'd1 == DIGITS_W) state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (buffer_reg == SECRET) begin
               state_next    = S_OPEN;
               fail_cnt_next = 4'd0;
            end else begin
               buffer_next    = '0;
               digit_cnt_next = 4'd0;
               if (fail_inc <= MAX_FAIL_W) fail_cnt_next = fail_inc[3:0];
               if (fail_inc == MAX_FAIL_W) begin
                  state_next = S_LOCKOUT;
                  timer_next = TIMER_LOAD;
               end else begin
                  state_next = S_ENTRY;
               end
            end
         end
         S_OPEN: begin
            if (bus.close) begin
               state_next     = S_ENTRY;
               buffer_next    = '0;
               digit_cnt_next = 4'd0;
            end
         end
         S_LOCKOUT: begin
            if (timer_reg == 16'd0) begin
               state_next    = S_ENTRY;
               fail_cnt_next = 4'd0;
            end else begin
               timer_next = timer_reg - 16'd1;
            end
         end
         default: state_next = S_ENTRY;
      endcase
   end

   assign bus.lock      = (state_reg != S_OPEN);
   assign bus.alarm     = (state_reg == S_LOCKOUT);
   assign bus.digit_cnt = digit_cnt_reg;
   assign bus.fail_cnt  = fail_cnt_reg;

endmodule

// File: tb/tb_elelock_seq.sv
// Directed bench for elelock_seq with SECRET=1234: vector table for entry/close/held-key
// behaviour plus hand-written lockout, fail-recovery and async-reset sequences.
module tb_elelock_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   elelock_seq_if bus ();

   elelock_seq #(
      .DIGITS         (4),
      .SECRET         (16'h1234),
      .MAX_FAIL       (3),
      .LOCKOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] key;
      logic       cls;
      logic       e_lock;
      logic       e_alarm;
      logic [3:0] e_dc;
      logic [3:0] e_fc;
   } vec_t;

   vec_t vt[$];

   localparam logic [9:0] K0 = 10'h000;
   localparam logic [9:0] K1 = 10'h002;
   localparam logic [9:0] K2 = 10'h004;
   localparam logic [9:0] K3 = 10'h008;
   localparam logic [9:0] K4 = 10'h010;
   localparam logic [9:0] K5 = 10'h020;

   task automatic add(input logic [9:0] key, input logic cls, input logic l,
                      input logic a, input logic [3:0] dc, input logic [3:0] fc);
      vec_t v;
      v.key = key; v.cls = cls; v.e_lock = l; v.e_alarm = a; v.e_dc = dc; v.e_fc = fc;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
      end else begin
         $display("ok   %s = %0d", name, actual);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int d);
      bus.tenkey = 10'(1 << d);
      step();
      bus.tenkey = K0;
      step();
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   task automatic do_close();
      bus.close = 1'b1;
      step();
      bus.close = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi_cnt;
      int guard;
      checks   = 0;
      failures = 0;
      rst_n      = 1'b0;
      bus.tenkey = K0;
      bus.close  = 1'b0;

      // Correct code, digits separated by idle cycles
      add(K1,0,1,0,1,0); add(K0,0,1,0,1,0);
      add(K2,0,1,0,2,0); add(K0,0,1,0,2,0);
      add(K3,0,1,0,3,0); add(K0,0,1,0,3,0);
      add(K4,0,1,0,4,0);                    // CHECK cycle, still locked
      add(K0,0,0,0,4,0); add(K0,0,0,0,4,0); // OPEN
      add(K0,1,1,0,0,0); add(K0,0,1,0,0,0); // close relocks
      // Held key yields one press; multi-hot ignored; rest of code proves nibble 1
      add(K1,0,1,0,1,0); add(K1,0,1,0,1,0); add(K1,0,1,0,1,0);
      add(K1,0,1,0,1,0); add(K1,0,1,0,1,0);
      add(10'h006,0,1,0,1,0); add(K0,0,1,0,1,0);
      add(10'h006,0,1,0,1,0); add(K0,0,1,0,1,0);
      add(K2,0,1,0,2,0); add(K0,0,1,0,2,0);
      add(K3,0,1,0,3,0); add(K0,0,1,0,3,0);
      add(K4,0,1,0,4,0); add(K0,0,0,0,4,0);
      add(K0,1,1,0,0,0); add(K0,0,1,0,0,0);
      // close together with key 3 discards the key
      add(K1,0,1,0,1,0); add(K0,0,1,0,1,0);
      add(K2,0,1,0,2,0); add(K0,0,1,0,2,0);
      add(K3,1,1,0,0,0); add(K0,0,1,0,0,0);
      add(K1,0,1,0,1,0); add(K0,0,1,0,1,0);
      add(K2,0,1,0,2,0); add(K0,0,1,0,2,0);
      add(K3,0,1,0,3,0); add(K0,0,1,0,3,0);
      add(K4,0,1,0,4,0); add(K0,0,0,0,4,0);
      add(K0,1,1,0,0,0); add(K0,0,1,0,0,0);

      #12;
      check("reset_lock",  int'(bus.lock), 1);
      check("reset_alarm", int'(bus.alarm), 0);
      check("reset_dc",    int'(bus.digit_cnt), 0);
      check("reset_fc",    int'(bus.fail_cnt), 0);
      rst_n = 1'b1;
      step();

      foreach (vt[i]) begin
         bus.tenkey = vt[i].key;
         bus.close  = vt[i].cls;
         step();
         check($sformatf("vec%0d_lock", i),  int'(bus.lock),      int'(vt[i].e_lock));
         check($sformatf("vec%0d_alarm", i), int'(bus.alarm),     int'(vt[i].e_alarm));
         check($sformatf("vec%0d_dc", i),    int'(bus.digit_cnt), int'(vt[i].e_dc));
         check($sformatf("vec%0d_fc", i),    int'(bus.fail_cnt),  int'(vt[i].e_fc));
      end
      bus.tenkey = K0;
      bus.close  = 1'b0;
      step();

      // Lockout after three wrong entries
      enter4(1, 2, 3, 5);
      check("lk_fc1", int'(bus.fail_cnt), 1);
      check("lk_dc1", int'(bus.digit_cnt), 0);
      check("lk_alarm1", int'(bus.alarm), 0);
      enter4(1, 2, 3, 5);
      check("lk_fc2", int'(bus.fail_cnt), 2);
      check("lk_alarm2", int'(bus.alarm), 0);
      enter4(1, 2, 3, 5);
      check("lk_fc3", int'(bus.fail_cnt), 3);
      check("lk_alarm3", int'(bus.alarm), 1);
      check("lk_lock3", int'(bus.lock), 1);
      hi_cnt = 1;
      guard  = 0;
      while (bus.alarm && guard < 40) begin
         bus.tenkey = (guard % 2 == 0) ? K1 : K0;
         bus.close  = (guard == 5);
         step();
         guard++;
         if (bus.alarm) begin
            hi_cnt++;
            check("lk_hold_dc", int'(bus.digit_cnt), 0);
            check("lk_hold_lock", int'(bus.lock), 1);
         end
      end
      bus.tenkey = K0;
      bus.close  = 1'b0;
      check("lk_alarm_cycles", hi_cnt, 16);
      check("lk_after_alarm", int'(bus.alarm), 0);
      check("lk_after_fc", int'(bus.fail_cnt), 0);
      check("lk_after_lock", int'(bus.lock), 1);
      step();
      check("lk_after_dc", int'(bus.digit_cnt), 0);
      enter4(1, 2, 3, 4);
      check("lk_reopen_lock", int'(bus.lock), 0);
      check("lk_reopen_fc", int'(bus.fail_cnt), 0);
      do_close();
      check("lk_reclose_lock", int'(bus.lock), 1);

      // One miss, then the right code clears the failure count
      enter4(9, 9, 9, 9);
      check("fr_fc1", int'(bus.fail_cnt), 1);
      check("fr_lock1", int'(bus.lock), 1);
      enter4(1, 2, 3, 4);
      check("fr_lock", int'(bus.lock), 0);
      check("fr_fc0", int'(bus.fail_cnt), 0);
      do_close();

      // Async reset between edges mid-entry with a pending failure
      enter4(5, 5, 5, 5);
      check("ar_fc_pre", int'(bus.fail_cnt), 1);
      press(1); press(2); press(3);
      check("ar_dc_pre", int'(bus.digit_cnt), 3);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_lock", int'(bus.lock), 1);
      check("ar_alarm", int'(bus.alarm), 0);
      check("ar_dc", int'(bus.digit_cnt), 0);
      check("ar_fc", int'(bus.fail_cnt), 0);
      #2;
      rst_n = 1'b1;
      step();
      check("ar_dc_post", int'(bus.digit_cnt), 0);
      press(4);
      check("ar_newdigit_dc", int'(bus.digit_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
